// File: rtl/cache_sync_responder.sv
// Miss-handshake responder: evicts dirty victims, fills the slot, then pulses sync to the row cache.
// Optional statistics counters are built only when SYNC_STATS_EN is defined.
module cache_sync_responder #(
  parameter int CHWIDTH   = 5,
  parameter int ADDRWIDTH = 17,
  parameter int TWB       = 4,
  parameter int TFILL     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic [CHWIDTH-1:0]   cRowId,
  input  logic [ADDRWIDTH-1:0] RowId,
  input  logic                 RD,
  input  logic                 WR,
  output logic                 sync,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [ADDRWIDTH-1:0] mem_row,
  output logic [CHWIDTH-1:0]   mem_slot,
  output logic                 busy,
  output logic [31:0]          miss_cnt,
  output logic [31:0]          wb_cnt
);

  localparam int CHROWS = 2 ** CHWIDTH;
  localparam int TMAX   = (TWB > TFILL) ? TWB : TFILL;
  localparam int CW     = $clog2(TMAX) + 1;
  localparam logic [CW-1:0] WB_LOAD   = CW'(TWB - 1);
  localparam logic [CW-1:0] FILL_LOAD = CW'(TFILL - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WB      = 3'd1,
    S_FILL    = 3'd2,
    S_SYNC    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CHWIDTH-1:0]     slot_q, slot_d;
  logic [ADDRWIDTH-1:0]   row_q, row_d;
  logic [ADDRWIDTH-1:0]   victim_q, victim_d;
  logic                   isw_q, isw_d;
  logic [CHROWS-1:0]      valid_q, valid_d;
  logic [CHROWS-1:0]      dirty_q, dirty_d;
  logic [ADDRWIDTH-1:0]   tag_q [CHROWS];
  logic [ADDRWIDTH-1:0]   tag_d [CHROWS];
  logic                   sync_q, sync_d;
  logic                   mem_rd_q, mem_rd_d;
  logic                   mem_wr_q, mem_wr_d;
  logic [ADDRWIDTH-1:0]   mem_row_q, mem_row_d;
  logic [CHWIDTH-1:0]     mem_slot_q, mem_slot_d;
  logic                   busy_q, busy_d;

  // A miss counts as a write whenever WR is set, so RD never steers the datapath.
  logic rd_unused_s;
  assign rd_unused_s = RD;

  // Next-state, slot-table and registered-output computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    slot_d   = slot_q;
    row_d    = row_q;
    victim_d = victim_q;
    isw_d    = isw_q;
    valid_d  = valid_q;
    dirty_d  = dirty_q;
    tag_d    = tag_q;
    sync_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hold) begin
          slot_d   = cRowId;
          row_d    = RowId;
          isw_d    = WR;
          victim_d = tag_q[cRowId];
          if (valid_q[cRowId] && dirty_q[cRowId]) begin
            state_d = S_WB;
            cnt_d   = WB_LOAD;
          end else begin
            state_d = S_FILL;
            cnt_d   = FILL_LOAD;
          end
        end else if (WR) begin
          dirty_d[cRowId] = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WB: begin
        if (!hold) begin
          state_d = S_IDLE;
        end else if (cnt_q == {CW{1'b0}}) begin
          state_d = S_FILL;
          cnt_d   = FILL_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_FILL: begin
        if (!hold) begin
          state_d = S_IDLE;
        end else if (cnt_q == {CW{1'b0}}) begin
          state_d         = S_SYNC;
          sync_d          = 1'b1;
          valid_d[slot_q] = 1'b1;
          dirty_d[slot_q] = isw_q;
          tag_d[slot_q]   = row_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_SYNC: begin
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!hold) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RELEASE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d   = (state_d != S_IDLE);
    mem_wr_d = (state_d == S_WB);
    mem_rd_d = (state_d == S_FILL);
    if (state_d == S_WB) begin
      mem_row_d  = victim_d;
      mem_slot_d = slot_d;
    end else if (state_d == S_FILL) begin
      mem_row_d  = row_d;
      mem_slot_d = slot_d;
    end else begin
      mem_row_d  = {ADDRWIDTH{1'b0}};
      mem_slot_d = {CHWIDTH{1'b0}};
    end
  end

  // State, slot table and output registers; reset empties the table.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CW{1'b0}};
      slot_q     <= {CHWIDTH{1'b0}};
      row_q      <= {ADDRWIDTH{1'b0}};
      victim_q   <= {ADDRWIDTH{1'b0}};
      isw_q      <= 1'b0;
      valid_q    <= {CHROWS{1'b0}};
      dirty_q    <= {CHROWS{1'b0}};
      for (int i = 0; i < CHROWS; i++) begin
        tag_q[i] <= {ADDRWIDTH{1'b0}};
      end
      sync_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_row_q  <= {ADDRWIDTH{1'b0}};
      mem_slot_q <= {CHWIDTH{1'b0}};
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      row_q      <= row_d;
      victim_q   <= victim_d;
      isw_q      <= isw_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      tag_q      <= tag_d;
      sync_q     <= sync_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
      mem_row_q  <= mem_row_d;
      mem_slot_q <= mem_slot_d;
      busy_q     <= busy_d;
    end
  end

  assign sync     = sync_q;
  assign mem_rd   = mem_rd_q;
  assign mem_wr   = mem_wr_q;
  assign mem_row  = mem_row_q;
  assign mem_slot = mem_slot_q;
  assign busy     = busy_q;

`ifdef SYNC_STATS_EN
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [31:0] wb_cnt_q, wb_cnt_d;

  // Completed misses count on SYNC entry, completed write-backs on WB->FILL; aborts never reach either.
  always_comb begin
    if (state_q == S_FILL && state_d == S_SYNC) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end else begin
      miss_cnt_d = miss_cnt_q;
    end
    if (state_q == S_WB && state_d == S_FILL) begin
      wb_cnt_d = wb_cnt_q + 32'd1;
    end else begin
      wb_cnt_d = wb_cnt_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miss_cnt_q <= 32'd0;
      wb_cnt_q   <= 32'd0;
    end else begin
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;
`else
  assign miss_cnt = 32'd0;
  assign wb_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_cache_sync_responder.sv
// Self-checking bench for cache_sync_responder: directed scenarios plus randomized misses
// checked against a slot-table reference model.
module tb_cache_sync_responder;
  localparam int CHW   = 5;
  localparam int AW    = 17;
  localparam int TWB   = 4;
  localparam int TFILL = 3;
  localparam int ROWS  = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           hold = 1'b0;
  logic [CHW-1:0] cRowId = '0;
  logic [AW-1:0]  RowId = '0;
  logic           RD = 1'b0;
  logic           WR = 1'b0;
  logic           sync, mem_rd, mem_wr, busy;
  logic [AW-1:0]  mem_row;
  logic [CHW-1:0] mem_slot;
  logic [31:0]    miss_cnt, wb_cnt;

  always #5 clk = ~clk;

  cache_sync_responder #(.CHWIDTH(CHW), .ADDRWIDTH(AW), .TWB(TWB), .TFILL(TFILL)) dut (
    .clk(clk), .rst(rst), .hold(hold), .cRowId(cRowId), .RowId(RowId), .RD(RD), .WR(WR),
    .sync(sync), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_row(mem_row), .mem_slot(mem_slot),
    .busy(busy), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  bit          m_valid [ROWS];
  bit          m_dirty [ROWS];
  logic [AW-1:0] m_tag [ROWS];
  int unsigned m_miss, m_wb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < ROWS; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
    m_miss = 0;
    m_wb   = 0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".sync"}, sync, 1'b0);
    chk({tag, ".mem_rd"}, mem_rd, 1'b0);
    chk({tag, ".mem_wr"}, mem_wr, 1'b0);
    chk({tag, ".mem_row"}, mem_row, '0);
    chk({tag, ".mem_slot"}, mem_slot, '0);
  endtask

  task automatic chk_cnt(input string tag);
`ifdef SYNC_STATS_EN
    chk({tag, ".miss_cnt"}, miss_cnt, m_miss);
    chk({tag, ".wb_cnt"}, wb_cnt, m_wb);
`else
    chk({tag, ".miss_cnt"}, miss_cnt, 32'd0);
    chk({tag, ".wb_cnt"}, wb_cnt, 32'd0);
`endif
  endtask

  // Expected bus during transfer cycle c (1-based) of a miss.
  task automatic chk_xfer(input string tag, input int c, input bit ev, input logic [AW-1:0] vic,
                          input logic [CHW-1:0] s, input logic [AW-1:0] r);
    int nwb;
    nwb = ev ? TWB : 0;
    chk({tag, ".busy"}, busy, 1'b1);
    chk({tag, ".sync"}, sync, 1'b0);
    if (c <= nwb) begin
      chk({tag, ".wb_wr"}, mem_wr, 1'b1);
      chk({tag, ".wb_rd"}, mem_rd, 1'b0);
      chk({tag, ".wb_row"}, mem_row, vic);
      chk({tag, ".wb_slot"}, mem_slot, s);
    end else begin
      chk({tag, ".fill_wr"}, mem_wr, 1'b0);
      chk({tag, ".fill_rd"}, mem_rd, 1'b1);
      chk({tag, ".fill_row"}, mem_row, r);
      chk({tag, ".fill_slot"}, mem_slot, s);
    end
  endtask

  task automatic scramble();
    RowId  = AW'($urandom);
    cRowId = CHW'($urandom);
    WR     = 1'($urandom);
    RD     = 1'($urandom);
  endtask

  // Full miss: capture, transfers, one sync pulse, hold kept for 'extra' cycles, release.
  task automatic do_miss(input string tag, input logic [CHW-1:0] s, input logic [AW-1:0] r,
                         input bit wr, input bit rd, input int extra);
    bit ev;
    logic [AW-1:0] vic;
    int len;
    ev  = m_valid[s] && m_dirty[s];
    vic = m_tag[s];
    len = (ev ? TWB : 0) + TFILL;
    hold = 1'b1; cRowId = s; RowId = r; WR = wr; RD = rd;
    for (int c = 1; c <= len; c++) begin
      tick();
      scramble();
      chk_xfer(tag, c, ev, vic, s, r);
    end
    tick();
    chk({tag, ".sync_pulse"}, sync, 1'b1);
    chk({tag, ".sync_busy"}, busy, 1'b1);
    chk({tag, ".sync_nowr"}, mem_wr, 1'b0);
    chk({tag, ".sync_nord"}, mem_rd, 1'b0);
    m_valid[s] = 1'b1;
    m_dirty[s] = wr;
    m_tag[s]   = r;
    m_miss++;
    if (ev) m_wb++;
    chk_cnt(tag);
    for (int k = 0; k < extra; k++) begin
      tick();
      chk({tag, ".held_sync"}, sync, 1'b0);
      chk({tag, ".held_busy"}, busy, 1'b1);
    end
    hold = 1'b0; WR = 1'b0; RD = 1'b0;
    tick();
    chk_idle({tag, ".release"});
  endtask

  // Miss dropped after 'drop_after' transfer cycles: no sync, no table change.
  task automatic abort_miss(input string tag, input logic [CHW-1:0] s, input logic [AW-1:0] r,
                            input bit wr, input int drop_after);
    bit ev;
    logic [AW-1:0] vic;
    ev  = m_valid[s] && m_dirty[s];
    vic = m_tag[s];
    hold = 1'b1; cRowId = s; RowId = r; WR = wr; RD = ~wr;
    for (int c = 1; c <= drop_after; c++) begin
      tick();
      chk_xfer(tag, c, ev, vic, s, r);
    end
    hold = 1'b0; WR = 1'b0; RD = 1'b0;
    tick();
    chk_idle({tag, ".abort"});
    chk_cnt({tag, ".abort"});
  endtask

  task automatic write_hit(input string tag, input logic [CHW-1:0] s);
    hold = 1'b0; WR = 1'b1; RD = 1'($urandom); cRowId = s; RowId = AW'($urandom);
    tick();
    WR = 1'b0; RD = 1'b0;
    chk_idle(tag);
    m_dirty[s] = 1'b1;
  endtask

  task automatic read_hit(input string tag, input logic [CHW-1:0] s);
    hold = 1'b0; RD = 1'b1; WR = 1'b0; cRowId = s;
    tick();
    RD = 1'b0;
    chk_idle(tag);
  endtask

  initial begin
    model_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    chk_cnt("reset");
    rst = 1'b1;
    tick();

    // Cold read miss, then dirty eviction.
    do_miss("cold", 5'd3, 17'h00ABC, 1'b0, 1'b1, 1);
    do_miss("wfill", 5'd5, 17'h01234, 1'b1, 1'b0, 1);
    do_miss("evict", 5'd5, 17'h00777, 1'b0, 1'b1, 1);

    // Write hit makes a clean slot dirty.
    do_miss("rfill7", 5'd7, 17'h00042, 1'b0, 1'b1, 1);
    read_hit("rhit7", 5'd7);
    write_hit("whit7", 5'd7);
    do_miss("wbhit7", 5'd7, 17'h00100, 1'b0, 1'b1, 1);

    // RD and WR together are a write; hold held 5 cycles after sync.
    do_miss("rdwr", 5'd10, 17'h00555, 1'b1, 1'b1, 5);
    do_miss("rdwr_ev", 5'd10, 17'h00556, 1'b0, 1'b1, 2);

    // Aborts: clean fill dropped in cycle 2; partial write-back reissued later.
    abort_miss("abort_fill", 5'd12, 17'h00AAA, 1'b0, 2);
    do_miss("after_abort", 5'd12, 17'h00AAB, 1'b0, 1'b1, 1);
    write_hit("whit7b", 5'd7);
    abort_miss("abort_wb", 5'd7, 17'h00200, 1'b0, 2);
    do_miss("wb_reissue", 5'd7, 17'h00201, 1'b0, 1'b1, 1);

    // Reset in the middle of a write-back clears outputs and the table.
    write_hit("whit10", 5'd10);
    hold = 1'b1; cRowId = 5'd10; RowId = 17'h00300; RD = 1'b1; WR = 1'b0;
    tick();
    chk("midwb.c1", mem_wr, 1'b1);
    tick();
    chk("midwb.c2", mem_wr, 1'b1);
    rst = 1'b0;
    #1;
    chk_idle("midwb_rst");
    chk("midwb_rst.miss_cnt", miss_cnt, 32'd0);
    chk("midwb_rst.wb_cnt", wb_cnt, 32'd0);
    hold = 1'b0; RD = 1'b0;
    model_reset();
    #2;
    rst = 1'b1;
    tick();
    chk_idle("post_rst");

    // One clean miss per slot, including the previously dirty ones.
    for (int i = 0; i < ROWS; i++) begin
      do_miss("sweep", CHW'(i), AW'($urandom), 1'b0, 1'b1, 1);
    end
    chk_cnt("sweep_end");

    // Randomized traffic concentrated on a few slots so evictions recur.
    for (int n = 0; n < 40; n++) begin
      int op;
      logic [CHW-1:0] s;
      int len;
      op = int'($urandom_range(4, 0));
      s  = CHW'($urandom_range(3, 0));
      len = ((m_valid[s] && m_dirty[s]) ? TWB : 0) + TFILL;
      case (op)
        0: write_hit("rnd_whit", s);
        1: read_hit("rnd_rhit", s);
        2: abort_miss("rnd_abort", s, AW'($urandom), 1'($urandom),
                      1 + int'($urandom_range(len - 1, 0)));
        default: do_miss("rnd_miss", s, AW'($urandom), 1'($urandom), 1'($urandom),
                         1 + int'($urandom_range(3, 0)));
      endcase
    end
    chk_cnt("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cache_sync_responder.md
# cache_sync_responder

Backing-store responder for the row cache's miss handshake. It watches the cache's `hold` (miss pending) and `cRowId` (victim/target slot) outputs, together with the `RD`/`WR`/`RowId` request, and performs the eviction (write-back) and fill transfers toward the DRAM bank model. When the transfer is complete it pulses `sync` back to the cache. It keeps its own per-slot tag/valid/dirty table, so it knows whether a victim must be written back.

## Interface
- `CHWIDTH`, 5: cache slot index width; `CHROWS = 2**CHWIDTH` slots.
- `ADDRWIDTH`, 17: DRAM row id width.
- `TWB`, 4: write-back transfer length in cycles (≥1).
- `TFILL`, 3: fill transfer length in cycles (≥1).

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `hold`  in  1  cache miss pending.
- `cRowId`  in  CHWIDTH  slot the cache allocates for the miss, or the hit slot.
- `RowId`  in  ADDRWIDTH  requested row.
- `RD`  in  1  read request.
- `WR`  in  1  write request.
- `sync`  out  1  one-cycle pulse: slot now holds `RowId`.
- `mem_rd`  out  1  fill transfer active.
- `mem_wr`  out  1  write-back transfer active.
- `mem_row`  out  ADDRWIDTH  row being transferred.
- `mem_slot`  out  CHWIDTH  slot being transferred.
- `busy`  out  1  FSM not in IDLE.
- `miss_cnt`  out  32  completed misses (see Configuration).
- `wb_cnt`  out  32  completed write-backs (see Configuration).

## Operation
- Slot table: `CHROWS` entries of {valid, dirty, tag[ADDRWIDTH]}.
- FSM states: IDLE, WB, FILL, SYNC, RELEASE.
- IDLE:
  - `hold`=1 latches `cRowId`→slot, `RowId`→row, `WR`→isw.
  - Go to WB if table[slot] is valid and dirty, else go to FILL.
- Write hit: in IDLE with `hold`=0 and `WR`=1, set table[`cRowId`].dirty=1. `RD` with `hold`=0 has no effect.
- WB: `mem_wr`=1, `mem_row`=old tag, `mem_slot`=slot, held for TWB cycles, then go to FILL.
- FILL: `mem_rd`=1, `mem_row`=latched row, `mem_slot`=slot, held for TFILL cycles, then go to SYNC.
- SYNC:
  - `sync`=1 for exactly one cycle.
  - Table[slot] ← {valid=1, dirty=isw, tag=row}.
  - Go to RELEASE.
- RELEASE: wait for `hold`=0, then go to IDLE. No second `sync` pulse while `hold` stays high.
- Abort: `hold`=0 observed in WB or FILL returns the FSM to IDLE next cycle, with no table update and no `sync`.
  - A write-back that was partially issued is reissued on the next miss to that slot, because dirty is still set.
- `RD` and `WR` both high at miss capture are treated as a write (isw=1).
- Inputs latched at capture; later changes to `RowId`/`cRowId` during a transfer are ignored.

## Timing
- Reset (`rst`=0, asynchronous):
  - FSM to IDLE, all table entries invalid and clean.
  - `sync`, `mem_rd`, `mem_wr`, `busy` = 0; `mem_row`, `mem_slot` = 0; counters = 0.
- Outputs are registered. `busy` rises the cycle after `hold` is sampled high.
- Clean miss, from the `hold` capture edge to the `sync` high cycle: 1 + TFILL cycles (4 at default).
- Dirty miss: 1 + TWB + TFILL cycles (8 at default).
- Down counters are `$clog2(max(TWB,TFILL))+1` bits, loaded with T−1 on state entry, and exit at 0.
- `mem_row`/`mem_slot` hold their value through a transfer and return to 0 in IDLE.
- Reset asserted mid-transfer: immediate return to IDLE, and the table is cleared.

## Configuration
- `SYNC_STATS_EN` defined:
  - `miss_cnt` increments on every SYNC cycle.
  - `wb_cnt` increments on every WB→FILL transition.
  - Both are 32-bit and wrap at 2^32.
  - Aborted misses are not counted.
- `SYNC_STATS_EN` undefined: `miss_cnt` and `wb_cnt` are tied to 0 and no counter registers exist.

## Test plan
- Cold read miss. Stimulus: reset, `RD`=1, `RowId`=17'h00ABC, `cRowId`=3, `hold`=1. Required: `mem_rd`=1 for 3 cycles with `mem_row`=17'h00ABC and `mem_slot`=3; `sync` pulses on cycle 4; no `mem_wr`.
- Dirty eviction. Stimulus: write miss fills slot 5 with row 0x1234 (dirty); then a read miss of row 0x0777 to slot 5. Required: `mem_wr`=1 for 4 cycles with `mem_row`=0x1234, then `mem_rd` for 3 cycles with `mem_row`=0x0777; `sync` at cycle 8; `wb_cnt`=1.
- Write hit marks dirty. Stimulus: read-fill slot 7, then `WR`=1 with `hold`=0 and `cRowId`=7, then a miss to slot 7. Required: WB phase occurs.
- Hold held high after sync. Stimulus: keep `hold`=1 for 5 cycles after the pulse. Required: exactly one `sync` pulse and `busy`=1 until `hold` drops.
- Abort and reset. Stimulus: drop `hold` during FILL cycle 2. Required: `busy`=0 next cycle, no `sync`, `miss_cnt` unchanged. Then drive `rst`=0 mid-WB. Required: all outputs 0 immediately.
- Count sweep (with `SYNC_STATS_EN`). Stimulus: 32 clean misses, one per slot. Required: `miss_cnt`=32, `wb_cnt`=0.
